pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 224, payload width per entry.
REQ-002 SHALL have parameter STICKY_W, default 1, width of never-squashed side-band (e.g. halt).
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port flush  in  1  synchronous squash of buffered payload.
REQ-007 SHALL have port clear_stats  in  1  synchronous clear of stall counter.
REQ-008 SHALL have port in_valid  in  1  upstream beat present.
REQ-009 SHALL have port in_ready  out  1  stage accepts a beat this cycle.
REQ-010 SHALL have port in_data  in  DATA_W  upstream payload.
REQ-011 SHALL have port in_sticky  in  STICKY_W  upstream side-band.
REQ-012 SHALL have port out_valid  out  1  downstream beat present.
REQ-013 SHALL have port out_ready  in  1  downstream accepts.
REQ-014 SHALL have port out_data  out  DATA_W  head payload.
REQ-015 SHALL have port out_sticky  out  STICKY_W  head side-band or pending flushed side-band.
REQ-016 SHALL have port occupancy  out  2  entries held (0..2).
REQ-017 SHALL have port stall_cycles  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-018 SHALL hold two entries, MAIN (head) and SKID, each {data, sticky}; states EMPTY, ONE, TWO.
REQ-019 SHALL drive in_ready = rst high and state != TWO, from registers only (no in/out combinational path to in_ready).
REQ-020 SHALL drive out_valid = (state != EMPTY); out_data = MAIN.data.
REQ-021 Transfer: in beat accepted when in_valid & in_ready; out beat when out_valid & out_ready.
REQ-022 EMPTY: accept -> MAIN, ONE; else stay.
REQ-023 ONE: accept & out -> MAIN replaced, ONE; accept only -> SKID, TWO; out only -> EMPTY; neither -> hold.
REQ-024 TWO: out -> SKID moves to MAIN, ONE; else hold; no accept possible.
REQ-025 Latency: accepted beat visible on out_* next cycle when stage was EMPTY or draining; FIFO order always.
REQ-026 flush: next state EMPTY, MAIN/SKID data zeroed; flush overrides acceptance (in beat that cycle discarded).
REQ-027 flush with simultaneous out transfer: that out beat counts as delivered.
REQ-028 Sticky never lost: on flush, PEND <= PEND | sticky of all held entries | (in_sticky if in_valid).
REQ-029 out_sticky = PEND when EMPTY, else MAIN.sticky.
REQ-030 Next accepted beat stores in_sticky | PEND; PEND cleared on that accept (unless flush same cycle).
REQ-031 stall_cycles increments when out_valid & !out_ready, saturates at all-ones; clear_stats wins over increment.
REQ-032 occupancy = 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-033 On rst low, asynchronously: state EMPTY, MAIN/SKID zero, PEND zero, stall_cycles zero.
REQ-034 During reset: in_ready 0, out_valid 0, out_data 0, out_sticky 0, occupancy 0.
REQ-035 Reset mid-transfer discards all entries including sticky; first accept allowed on first edge after release.

Structure
REQ-036 Package pipe_pkg SHALL hold enum pipe_buf_state_t {EMPTY, ONE, TWO} and default width constants.
REQ-037 Stall counter SHALL be sub-module sat_counter (params WIDTH; ports clk, rst, clr, inc, count).
REQ-038 Instances replacing fixed stage registers SHALL set DATA_W to packed payload width.

Verification
REQ-039 Stream 0x11,0x22,0x33 with out_ready=1 -> out each one cycle later, in order, occupancy never >1.
REQ-040 Push 0xA,0xB with out_ready=0 -> occupancy 2, in_ready 0, stall_cycles counts 1,2,...; raise out_ready -> 0xA then 0xB.
REQ-041 TWO state, in_sticky=1 on SKID entry, flush -> out_valid 0, out_sticky 1; next accept 0x5 sticky 0 -> out_sticky 1, PEND cleared.
REQ-042 flush and in_valid same cycle with 0x77 -> 0x77 never appears on out.
REQ-043 CNT_W=4, hold back-pressure 20 cycles -> stall_cycles 15; clear_stats -> 0.
REQ-044 rst low while occupancy 2 -> all outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the two-entry skid pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_buf_state_t;

  localparam int DEF_DATA_W   = 224;
  localparam int DEF_STICKY_W = 1;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: count updates on the edge after inc/clr. No backpressure.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + ONE_V;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer: in_ready is registered-only, accepted beat appears next cycle.
// Backpressure: in_ready drops when both entries are full; flush squashes data but keeps sticky bits.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int STICKY_W = DEF_STICKY_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                clear_stats,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [STICKY_W-1:0] in_sticky,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [STICKY_W-1:0] out_sticky,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cycles
);

  pipe_buf_state_t     state_q, state_d;
  logic [DATA_W-1:0]   main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
  logic [STICKY_W-1:0] main_stk_q, main_stk_d, skid_stk_q, skid_stk_d;
  logic [STICKY_W-1:0] pend_q, pend_d;
  logic [STICKY_W-1:0] in_stk_eff, held_stk;
  logic                acc, pop;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (acc) state_d = ONE;
        ONE: begin
          if (acc && !pop) state_d = TWO;
          else if (!acc && pop) state_d = EMPTY;
        end
        TWO: if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    occupancy  = 2'd0;
    out_sticky = pend_q;
    case (state_q)
      EMPTY: begin
        in_ready = rst;
      end
      ONE: begin
        in_ready   = rst;
        out_valid  = 1'b1;
        occupancy  = 2'd1;
        out_sticky = main_stk_q;
      end
      TWO: begin
        out_valid  = 1'b1;
        occupancy  = 2'd2;
        out_sticky = main_stk_q;
      end
      default: ;
    endcase
  end

  assign out_data = main_dat_q;

  // Sticky bits that a flush must fold into PEND so they are never dropped.
  always_comb begin
    held_stk = '0;
    if (state_q != EMPTY) held_stk = held_stk | main_stk_q;
    if (state_q == TWO)   held_stk = held_stk | skid_stk_q;
    if (in_valid)         held_stk = held_stk | in_sticky;
  end

  assign in_stk_eff = in_sticky | pend_q;

  always_comb begin
    main_dat_d = main_dat_q;
    main_stk_d = main_stk_q;
    skid_dat_d = skid_dat_q;
    skid_stk_d = skid_stk_q;
    pend_d     = pend_q;
    if (flush) begin
      main_dat_d = '0;
      main_stk_d = '0;
      skid_dat_d = '0;
      skid_stk_d = '0;
      pend_d     = pend_q | held_stk;
    end else begin
      if (acc) pend_d = '0;
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_dat_d = in_data;
            main_stk_d = in_stk_eff;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_dat_d = in_data;
            main_stk_d = in_stk_eff;
          end else if (acc) begin
            skid_dat_d = in_data;
            skid_stk_d = in_stk_eff;
          end else if (pop) begin
            main_dat_d = '0;
            main_stk_d = '0;
          end
        end
        TWO: begin
          if (pop) begin
            main_dat_d = skid_dat_q;
            main_stk_d = skid_stk_q;
            skid_dat_d = '0;
            skid_stk_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_dat_q <= '0;
      main_stk_q <= '0;
      skid_dat_q <= '0;
      skid_stk_q <= '0;
      pend_q     <= '0;
    end else begin
      main_dat_q <= main_dat_d;
      main_stk_q <= main_stk_d;
      skid_dat_q <= skid_dat_d;
      skid_stk_q <= skid_stk_d;
      pend_q     <= pend_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear_stats),
    .inc  (out_valid & ~out_ready),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed plus random stimulus against a queue-based model of the skid stage.
module tb_pipe_skid_stage;

  localparam int DW   = 32;
  localparam int SW   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, clear_stats = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_sticky = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sticky;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  ent_t          mq[$];
  logic [SW-1:0] m_pend = '0;
  int            m_stall = 0;

  pipe_skid_stage #(.DATA_W(DW), .STICKY_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clear_stats(clear_stats),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sticky(out_sticky),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    chk({tag, ".stall"},     64'(stall_cycles), 64'(m_stall));
    if (mq.size() > 0) begin
      chk({tag, ".out_data"},   64'(out_data),   64'(mq[0].d));
      chk({tag, ".out_sticky"}, 64'(out_sticky), 64'(mq[0].s));
    end else begin
      chk({tag, ".out_sticky"}, 64'(out_sticky), 64'(m_pend));
    end
  endtask

  // One clock: apply inputs, check current outputs, then advance the model across the edge.
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic ordy,
                      input logic fl, input logic clr);
    bit acc, pop, stall_inc;
    in_valid = v; in_data = d; in_sticky = s; out_ready = ordy;
    flush = fl; clear_stats = clr;
    #1;
    cmp_all(tag);
    acc       = v && (mq.size() < 2);
    pop       = (mq.size() > 0) && ordy;
    stall_inc = (mq.size() > 0) && !ordy;
    @(posedge clk);
    #1;
    if (clr) m_stall = 0;
    else if (stall_inc && m_stall < CMAX) m_stall++;
    if (fl) begin
      foreach (mq[i]) m_pend |= mq[i].s;
      if (v) m_pend |= s;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{d: d, s: s | m_pend});
        m_pend = '0;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},   64'(in_ready),     64'd0);
    chk({tag, ".out_valid"},  64'(out_valid),    64'd0);
    chk({tag, ".out_data"},   64'(out_data),     64'd0);
    chk({tag, ".out_sticky"}, 64'(out_sticky),   64'd0);
    chk({tag, ".occupancy"},  64'(occupancy),    64'd0);
    chk({tag, ".stall"},      64'(stall_cycles), 64'd0);
  endtask

  initial begin
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Stream with free-flowing downstream; first beat accepted on first edge after release.
    step("stream0", 1, 32'h11, 0, 1, 0, 0);
    step("stream1", 1, 32'h22, 0, 1, 0, 0);
    step("stream2", 1, 32'h33, 0, 1, 0, 0);
    step("stream3", 0, 0, 0, 1, 0, 0);
    chk("stream.empty_occ", 64'(occupancy), 64'd0);

    // Fill both entries under backpressure, watch stall count, then drain in order.
    step("bp_a", 1, 32'hA, 0, 0, 0, 0);
    step("bp_b", 1, 32'hB, 0, 0, 0, 0);
    chk("bp.occ2", 64'(occupancy), 64'd2);
    chk("bp.in_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) step("bp_hold", 1, 32'hC, 0, 0, 0, 0);
    step("drain_a", 0, 0, 0, 1, 0, 0);
    step("drain_b", 0, 0, 0, 1, 0, 0);
    step("drain_e", 0, 0, 0, 1, 0, 1);

    // Flush in TWO with sticky on the SKID entry; sticky must survive via PEND.
    step("stk_m", 1, 32'h1, 0, 0, 0, 0);
    step("stk_s", 1, 32'h2, 1, 0, 0, 0);
    step("stk_fl", 0, 0, 0, 0, 1, 0);
    chk("stk.out_valid", 64'(out_valid), 64'd0);
    chk("stk.out_sticky", 64'(out_sticky), 64'd1);
    chk("stk.out_data0", 64'(out_data), 64'd0);
    step("stk_acc5", 1, 32'h5, 0, 0, 0, 0);
    chk("stk.acc_sticky", 64'(out_sticky), 64'd1);
    step("stk_pop", 0, 0, 0, 1, 0, 0);
    chk("stk.pend_clr", 64'(out_sticky), 64'd0);

    // Beat offered during flush must never appear.
    step("fl77", 1, 32'h77, 0, 1, 1, 0);
    step("fl77_chk", 0, 0, 0, 1, 0, 0);
    chk("fl77.out_valid", 64'(out_valid), 64'd0);

    // Stall counter saturation at all-ones, then clear.
    step("sat_load", 1, 32'h9, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step("sat_hold", 0, 0, 0, 0, 0, 0);
    chk("sat.15", 64'(stall_cycles), 64'd15);
    step("sat_clr", 0, 0, 0, 0, 0, 1);
    chk("sat.clr0", 64'(stall_cycles), 64'd0);
    step("sat_drain", 0, 0, 0, 1, 1, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), DW'($urandom), SW'($urandom_range(0, 7) == 0 ? $urandom : 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset while full: outputs drop without a clock edge.
    step("ar_a", 1, 32'hE1, 2, 0, 1, 0);
    step("ar_a2", 1, 32'hE2, 0, 0, 0, 0);
    step("ar_b", 1, 32'hE3, 1, 0, 0, 0);
    chk("ar.occ2", 64'(occupancy), 64'd2);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    mq.delete();
    m_pend  = '0;
    m_stall = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1, 32'h42, 0, 0, 0, 0);
    step("post_rst2", 0, 0, 0, 1, 0, 0);
    step("post_rst3", 0, 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
